// File: rtl/jb_prach_oran_pkg.sv
// Shared PRACH O-RAN request-path definitions.
// Instantiating modules size the request FIFO from these.
package jb_prach_oran_pkg;

    localparam int PRACH_REQ_W     = 28;
    localparam int PRACH_REQ_DEPTH = 16;

    typedef logic [PRACH_REQ_W-1:0] prach_req_t;

endpackage

// File: rtl/jb_prach_oran_dmem.sv
// Distributed RAM: synchronous write port, asynchronous read port.
// Contents are not reset.
module jb_prach_oran_dmem #(
    parameter int DATA_W = 28,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] a,
    input  logic [DATA_W-1:0]        d,
    input  logic [$clog2(DEPTH)-1:0] dpra,
    output logic [DATA_W-1:0]        dpo
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[a] <= d;
        end
    end

    assign dpo = mem[dpra];

endmodule

// File: rtl/jb_prach_oran_request_queue.sv
// Show-ahead request FIFO between the C-plane request parser and the PRACH scheduler.
// Flags are registered from the next level so they move on the same edge as level.
module jb_prach_oran_request_queue
    import jb_prach_oran_pkg::*;
#(
    parameter int DATA_W      = PRACH_REQ_W,
    parameter int DEPTH       = PRACH_REQ_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   write,
    input  logic [DATA_W-1:0]      write_data,
    input  logic                   read,
    output logic [DATA_W-1:0]      read_data,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic          wr_acc;
    logic          rd_acc;
    logic [LW-1:0] level_nxt;

    // A read on a full queue frees the slot the write needs; a write on an
    // empty queue cannot be read in the same cycle (no bypass).
    always_comb begin
        wr_acc    = write && (!full || read) && !flush && !rst;
        rd_acc    = read && !empty && !flush && !rst;
        level_nxt = level;
        case ({wr_acc, rd_acc})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            waddr       <= '0;
            raddr       <= '0;
            level       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                waddr <= waddr + AW'(1);
            end
            if (rd_acc) begin
                raddr <= raddr + AW'(1);
            end
            level       <= level_nxt;
            full        <= (level_nxt == LW'(DEPTH));
            empty       <= (level_nxt == '0);
            almost_full <= (level_nxt >= LW'(AFULL_LEVEL));
            overflow    <= write && full && !read;
            underflow   <= read && empty;
        end
    end

    jb_prach_oran_dmem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dmem (
        .clk  (clk),
        .we   (wr_acc),
        .a    (waddr),
        .d    (write_data),
        .dpra (raddr),
        .dpo  (read_data)
    );

endmodule

// File: tb/tb_jb_prach_oran_request_queue.sv
// Bench: directed vector table on the default 28x16 queue, random traffic
// against a reference queue on a 8x4 instance.
module tb_jb_prach_oran_request_queue;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        a_flush, a_write, a_read;
    logic [27:0] a_wd, a_rd;
    logic        a_full, a_empty, a_af, a_ovf, a_udf;
    logic [4:0]  a_level;

    jb_prach_oran_request_queue dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .write(a_write), .write_data(a_wd),
        .read(a_read), .read_data(a_rd), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .level(a_level), .overflow(a_ovf), .underflow(a_udf)
    );

    // Small instance for wrap-heavy random traffic
    logic       b_flush, b_write, b_read;
    logic [7:0] b_wd, b_rd;
    logic       b_full, b_empty, b_af, b_ovf, b_udf;
    logic [2:0] b_level;

    jb_prach_oran_request_queue #(.DATA_W(8), .DEPTH(4), .AFULL_LEVEL(3)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .write(b_write), .write_data(b_wd),
        .read(b_read), .read_data(b_rd), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .level(b_level), .overflow(b_ovf), .underflow(b_udf)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          wr, rd, fl;
        logic [27:0] d;
        int          lvl;
        bit          full, empty, af, ovf, udf, chk_rd;
        logic [27:0] rdv;
    } vec_t;

    vec_t vq[$];

    function automatic void add(bit wr, bit rd, bit fl, logic [27:0] d, int lvl,
                                bit efull, bit eempty, bit eaf, bit eovf, bit eudf,
                                bit chk_rd, logic [27:0] rdv);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.d = d; v.lvl = lvl;
        v.full = efull; v.empty = eempty; v.af = eaf; v.ovf = eovf; v.udf = eudf;
        v.chk_rd = chk_rd; v.rdv = rdv;
        vq.push_back(v);
    endfunction

    initial begin
        int q[$];
        bit wr, rd, fl, racc, wacc, eovf, eudf;
        logic [7:0] d;

        rst = 1'b1;
        a_flush = 0; a_write = 0; a_read = 0; a_wd = '0;
        b_flush = 0; b_write = 0; b_read = 0; b_wd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", a_level, 0);
        chk("rst_empty", a_empty, 1);
        chk("rst_full", a_full, 0);
        chk("rst_afull", a_af, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("rst_b_empty", b_empty, 1);
        rst = 1'b0;

        // Fill with 1..16; head stays 0x1
        for (int i = 1; i <= 16; i++)
            add(1, 0, 0, 28'(i), i, i == 16, 0, i >= 14, 0, 0, 1, 28'h1);
        // Overflow attempt then idle
        add(1, 0, 0, 28'hFFF_FFFF, 16, 1, 0, 1, 1, 0, 1, 28'h1);
        add(0, 0, 0, 28'h0,        16, 1, 0, 1, 0, 0, 1, 28'h1);
        // Read+write while full
        add(1, 1, 0, 28'hABC_DEF0, 16, 1, 0, 1, 0, 0, 1, 28'h2);
        // Drain: remaining order 2..16 then 0xABCDEF0
        for (int j = 1; j <= 16; j++)
            add(0, 1, 0, 28'h0, 16 - j, 0, j == 16, (16 - j) >= 14, 0, 0,
                j < 16, (j <= 14) ? 28'(j + 2) : 28'hABC_DEF0);
        // Underflow and its one-cycle width
        add(0, 1, 0, 28'h0, 0, 0, 1, 0, 0, 1, 0, 28'h0);
        add(0, 0, 0, 28'h0, 0, 0, 1, 0, 0, 0, 0, 28'h0);
        // Read+write on empty: write lands, read rejected
        add(1, 1, 0, 28'h123, 1, 0, 0, 0, 0, 1, 1, 28'h123);
        add(1, 0, 0, 28'h456, 2, 0, 0, 0, 0, 0, 1, 28'h123);
        // Flush wins over write and read
        add(1, 1, 1, 28'h789, 0, 0, 1, 0, 0, 0, 0, 28'h0);
        add(0, 0, 0, 28'h0,   0, 0, 1, 0, 0, 0, 0, 28'h0);

        foreach (vq[i]) begin
            a_write = vq[i].wr; a_read = vq[i].rd; a_flush = vq[i].fl; a_wd = vq[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", i), a_level, vq[i].lvl);
            chk($sformatf("v%0d_full", i), a_full, vq[i].full);
            chk($sformatf("v%0d_empty", i), a_empty, vq[i].empty);
            chk($sformatf("v%0d_afull", i), a_af, vq[i].af);
            chk($sformatf("v%0d_ovf", i), a_ovf, vq[i].ovf);
            chk($sformatf("v%0d_udf", i), a_udf, vq[i].udf);
            if (vq[i].chk_rd) chk($sformatf("v%0d_rdata", i), a_rd, vq[i].rdv);
        end
        a_write = 0; a_read = 0; a_flush = 0;

        // Reset mid-burst
        for (int i = 0; i < 3; i++) begin
            a_write = 1; a_wd = 28'(i + 40);
            @(posedge clk);
            #1;
        end
        chk("burst_level", a_level, 3);
        rst = 1; a_wd = 28'h55;
        @(posedge clk);
        #1;
        rst = 0; a_write = 0;
        chk("midrst_level", a_level, 0);
        chk("midrst_empty", a_empty, 1);
        @(posedge clk);
        #1;
        chk("postrst_level", a_level, 0);

        // Random traffic vs. reference queue
        for (int c = 0; c < 1000; c++) begin
            int pw;
            pw = ((c / 50) % 2 == 0) ? 70 : 30;
            wr = ($urandom_range(0, 99) < pw);
            rd = ($urandom_range(0, 99) < 100 - pw);
            fl = (c == 500);
            if (fl) wr = 1;
            d = 8'($urandom);
            if (q.size() > 0) chk($sformatf("r%0d_head", c), b_rd, 64'(q[0]));
            b_write = wr; b_read = rd; b_flush = fl; b_wd = d;
            @(posedge clk);
            #1;
            if (fl) begin
                q.delete();
                eovf = 0; eudf = 0;
            end else begin
                eovf = wr && q.size() == 4 && !rd;
                eudf = rd && q.size() == 0;
                racc = rd && q.size() > 0;
                wacc = wr && (q.size() < 4 || rd);
                if (racc) void'(q.pop_front());
                if (wacc) q.push_back(int'(d));
            end
            chk($sformatf("r%0d_level", c), b_level, 64'(q.size()));
            chk($sformatf("r%0d_empty", c), b_empty, q.size() == 0);
            chk($sformatf("r%0d_full", c), b_full, q.size() == 4);
            chk($sformatf("r%0d_afull", c), b_af, q.size() >= 3);
            chk($sformatf("r%0d_ovf", c), b_ovf, eovf);
            chk($sformatf("r%0d_udf", c), b_udf, eudf);
        end
        b_write = 0; b_read = 0; b_flush = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jb_prach_oran_request_queue.md
# jb_prach_oran_request_queue

Parametrised single-clock request FIFO for the PRACH O-RAN request path. It generalises the fixed 28x16 request FIFO:
- configurable width and depth;
- occupancy level and almost-full outputs;
- underflow reporting and synchronous flush;
- strict protection of stored data against writes while full.

It sits between the O-RAN C-plane request parser (writer) and the PRACH request scheduler (reader).

## Interface
Parameters:
- DATA_W, 28, request word width in bits (≥1).
- DEPTH, 16, number of entries; power of two, ≥2.
- AFULL_LEVEL, DEPTH-2, occupancy at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous discard of all contents.
- write  in  1  push write_data this cycle.
- write_data  in  DATA_W  request word.
- read  in  1  pop head entry this cycle.
- read_data  out  DATA_W  head entry (show-ahead).
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AFULL_LEVEL.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

## Operation
- Storage is DEPTH x DATA_W distributed RAM with asynchronous read at raddr and synchronous write at waddr. Memory contents are not reset.
- Both pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 → 0.
- Write is accepted if write && (~full || read).
  - Accepted: RAM written, waddr increments.
  - Rejected (write && full && ~read): RAM not written, no pointer change, overflow pulses.
- Read is accepted if read && ~empty. Accepted: raddr increments.
  - Rejected (read && empty): underflow pulses.
  - Simultaneous write and read on empty: write accepted, read rejected. There is no bypass.
- level: +1 on write-only accept, −1 on read-only accept, unchanged when both are accepted or neither is.
- full, empty and almost_full are registered and derived from the next value of level. They change in the same edge as level.
- Priority: rst > flush > write/read.
  - flush clears pointers and level, and sets empty=1, full=0, almost_full=0.
  - Write/read in a flush cycle are ignored.
  - No overflow or underflow pulse is raised in a flush cycle.
- Reset values: full 0, empty 1, almost_full 0, level 0, overflow 0, underflow 0, pointers 0. read_data is undefined while empty.

## Timing
- Write at edge N: entry is visible on read_data (if it is the head) and empty=0 after edge N. Write-to-read latency is 1 cycle.
- read_data always shows the entry at raddr combinationally. The read at edge N consumes the word presented before edge N.
- overflow and underflow are registered and high for exactly the cycle after the rejected request. They are cleared every other cycle.
- Full plus simultaneous read and write: both accepted, full stays 1, level stays DEPTH, no overflow.
- Back-to-back writes and reads are sustained at 1 per cycle indefinitely, including across pointer wrap.
- Reset or flush mid-burst takes effect at that edge. The next cycle sees empty=1 and level=0.

## Structure
- Package jb_prach_oran_pkg holds:
  - PRACH_REQ_W = 28 and PRACH_REQ_DEPTH = 16, used by instantiating modules;
  - the request word typedef prach_req_t (logic [PRACH_REQ_W-1:0]).
- Sub-module jb_prach_oran_dmem: parametrised (DATA_W, DEPTH) distributed RAM.
  - Ports: clk, we, a, d, dpra, dpo.
  - Write-enable is driven by the accepted-write term only.
- Control (pointers, level, flags) lives in jb_prach_oran_request_queue itself. No separate FSM module.

## Test plan
- Default params, reset, then 16 writes of 0x000_0001..0x000_0010:
  - after the 16th write, full=1 and level=16;
  - almost_full rises after the 14th write.
- Full FIFO, write 0xFFF_FFFF with read=0:
  - overflow pulses for 1 cycle and level stays 16;
  - draining returns 0x1..0x10 in order, with no 0xFFF_FFFF.
- Full FIFO, simultaneous read+write of 0xABC_DEF0 for 1 cycle:
  - head 0x1 is consumed, full stays 1, no overflow;
  - the last drained word is 0xABC_DEF0.
- Empty FIFO, read=1 alone:
  - underflow pulses 1 cycle, level stays 0.
- Empty FIFO, read+write of 0x123 in the same cycle:
  - level=1, empty=0, read_data=0x123, underflow pulses.
- DEPTH=4, AFULL_LEVEL=3, 1000 cycles of random read/write against a reference queue:
  - data order and level match across many pointer wraps;
  - a flush at cycle 500 with write=1 gives level=0, empty=1, and discards that write.
